// File: rtl/axis_i2c_init_seq_if.sv
// axis_if: 8-bit AXI-Stream byte channel between axis_i2c_init_seq and the I2C master top.
interface axis_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_i2c_init_seq.sv
// Register-init sequencer: walks a {reg,data} table and emits 3-byte I2C write bursts on AXI-Stream.
// Optional AXIS_I2C_SEQ_END_MARKER_EN: a fetched 16'hFFFF entry ends the sequence early.
module axis_i2c_init_seq #(
    parameter logic [6:0]  DEV_ADDR   = 7'h3C,
    parameter int unsigned TBL_DEPTH  = 16,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         tbl_we_i,
    input  logic [$clog2(TBL_DEPTH)-1:0] tbl_addr_i,
    input  logic [15:0]                  tbl_wdata_i,
    input  logic [$clog2(TBL_DEPTH):0]   cmd_cnt_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    axis_if.master                       m_axis
);
    localparam int unsigned AW = $clog2(TBL_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, GAP, FIN} state_t;

    state_t        state;
    logic [15:0]   mem [TBL_DEPTH];
    logic [15:0]   rd_data;
    logic [15:0]   entry;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_nxt;
    logic [GW-1:0] gap_cnt;
    logic [1:0]    beat;
    logic          rd_wait;
    logic          end_marker;

    assign idx_nxt = idx + CW'(1);

`ifdef AXIS_I2C_SEQ_END_MARKER_EN
    assign end_marker = (rd_data == 16'hFFFF);
`else
    assign end_marker = 1'b0;
`endif

    // Table is not reset; busy_o is registered and low only in IDLE, so it gates writes.
    always_ff @(posedge clk_i) begin
        if (tbl_we_i && !busy_o)
            mem[tbl_addr_i] <= tbl_wdata_i;
        rd_data <= mem[idx[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state         <= IDLE;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            cnt           <= '0;
            idx           <= '0;
            gap_cnt       <= '0;
            beat          <= '0;
            rd_wait       <= 1'b0;
            entry         <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        idx     <= '0;
                        rd_wait <= 1'b0;
                        busy_o  <= 1'b1;
                        cnt     <= (cmd_cnt_i > CW'(TBL_DEPTH)) ? CW'(TBL_DEPTH) : cmd_cnt_i;
                        if (cmd_cnt_i == '0) begin
                            state  <= FIN;
                            done_o <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                // First FETCH cycle lets the RAM read settle; second one captures the entry.
                FETCH: begin
                    if (!rd_wait) begin
                        rd_wait <= 1'b1;
                    end else begin
                        rd_wait <= 1'b0;
                        entry   <= rd_data;
                        if (end_marker) begin
                            state  <= FIN;
                            done_o <= 1'b1;
                        end else begin
                            beat          <= 2'd0;
                            m_axis.tvalid <= 1'b1;
                            m_axis.tdata  <= {DEV_ADDR, 1'b0};
                            state         <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (m_axis.tready) begin
                        case (beat)
                            2'd0: begin
                                m_axis.tdata <= entry[15:8];
                                beat         <= 2'd1;
                            end
                            2'd1: begin
                                m_axis.tdata <= entry[7:0];
                                beat         <= 2'd2;
                            end
                            default: begin
                                m_axis.tvalid <= 1'b0;
                                gap_cnt       <= GW'(GAP_CYCLES - 1);
                                state         <= GAP;
                            end
                        endcase
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        idx <= idx_nxt;
                        if (idx_nxt == cnt) begin
                            state  <= FIN;
                            done_o <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                FIN: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_i2c_init_seq.sv
// Self-checking bench for axis_i2c_init_seq: vector table, corner sequences and randomized runs vs a timing model.
`timescale 1ns/1ps
module tb_axis_i2c_init_seq;
    localparam int DEPTH = 16;
    localparam int GAP   = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [6:0] DEV = 7'h3C;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          tbl_we = 1'b0;
    logic [AW-1:0] tbl_addr = '0;
    logic [15:0]   tbl_wdata = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          start = 1'b0;
    logic          tready = 1'b0;
    logic          busy;
    logic          done;

    axis_if m_axis ();
    assign m_axis.tready = tready;

    axis_i2c_init_seq #(.DEV_ADDR(DEV), .TBL_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .tbl_we_i   (tbl_we),
        .tbl_addr_i (tbl_addr),
        .tbl_wdata_i(tbl_wdata),
        .cmd_cnt_i  (cmd_cnt),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .m_axis     (m_axis)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [15:0] tbl_m [DEPTH];

    int         hs_cyc[$];
    logic [7:0] hs_dat[$];
    int         done_cyc[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tready = 1'b0;
                1: tready = 1'b1;
                2: tready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    logic       edge_ok = 1'b0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = '0;
    always @(posedge clk) edge_ok <= arstn;

    always @(negedge clk) begin
        if (edge_ok && pv && !pr) begin
            chk("hold_tvalid", m_axis.tvalid, 1);
            chk("hold_tdata", m_axis.tdata, pd);
        end
        if (m_axis.tvalid && tready) begin
            hs_cyc.push_back(cyc);
            hs_dat.push_back(m_axis.tdata);
        end
        if (done) done_cyc.push_back(cyc);
        pv = m_axis.tvalid;
        pr = tready;
        pd = m_axis.tdata;
    end

    task automatic write_entry(input int a, input logic [15:0] d);
        tbl_we    = 1'b1;
        tbl_addr  = AW'(a);
        tbl_wdata = d;
        tbl_m[a]  = d;
        tick();
        tbl_we = 1'b0;
    endtask

    // Expected bytes and their cycles come from the per-command cost: 2 fetch + 3 bytes + GAP idle.
    task automatic run_seq(input logic [CW-1:0] cnt, input int mode, input bit wr_busy,
                           input bit wr_start, input logic [15:0] wval, input int exp_nb);
        int c0;
        int n;
        int t;
        int exp_done;
        bit marked;
        logic [15:0] e;
        logic [7:0] eb[$];
        int ec[$];
        hs_cyc.delete();
        hs_dat.delete();
        done_cyc.delete();
        ready_mode = mode;
        if (wr_start) begin
            tbl_we    = 1'b1;
            tbl_addr  = '0;
            tbl_wdata = wval;
            tbl_m[0]  = wval;
        end
        cmd_cnt = cnt;
        start   = 1'b1;
        c0      = cyc;
        n       = (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
        t       = c0;
        marked  = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = tbl_m[i];
`ifdef AXIS_I2C_SEQ_END_MARKER_EN
            if (e == 16'hFFFF) begin
                marked = 1'b1;
                break;
            end
`endif
            eb.push_back({DEV, 1'b0}); ec.push_back(t + 3);
            eb.push_back(e[15:8]);     ec.push_back(t + 4);
            eb.push_back(e[7:0]);      ec.push_back(t + 5);
            t += 5 + GAP;
        end
        exp_done = marked ? t + 3 : t + 1;

        tick();
        start  = 1'b0;
        tbl_we = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 4000 && done_cyc.size() == 0; i++) begin
            if (wr_busy && i == 3) begin
                tbl_we    = 1'b1;
                tbl_addr  = '0;
                tbl_wdata = wval;
            end else begin
                tbl_we = 1'b0;
            end
            tick();
        end
        tbl_we = 1'b0;
        chk("done_seen", done_cyc.size() != 0, 1);
        chk("busy_after_done", busy, 0);
        chk("tvalid_after_done", m_axis.tvalid, 0);
        repeat (3) tick();
        chk("done_pulses", done_cyc.size(), 1);
        chk("nbytes", hs_dat.size(), eb.size());
        if (exp_nb >= 0) chk("nbytes_tbl", hs_dat.size(), exp_nb);
        for (int k = 0; k < eb.size() && k < hs_dat.size(); k++) begin
            chk("byte", hs_dat[k], eb[k]);
            if (mode == 1) chk("byte_cycle", hs_cyc[k] - c0, ec[k] - c0);
        end
        if (mode == 1 && done_cyc.size() > 0) chk("done_cycle", done_cyc[0] - c0, exp_done - c0);
    endtask

    typedef struct {
        logic [15:0]   e0;
        logic [15:0]   e1;
        logic [15:0]   e2;
        logic [CW-1:0] cnt;
        int            mode;
        int            exp_nb;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{16'h1234, 16'hABCD, 16'h0000, CW'(2), 1, 6};
        vecs[1] = '{16'h1234, 16'hABCD, 16'h0000, CW'(2), 2, 6};
        vecs[2] = '{16'h1234, 16'hABCD, 16'h0000, CW'(0), 1, 0};
`ifdef AXIS_I2C_SEQ_END_MARKER_EN
        vecs[3] = '{16'h0102, 16'hFFFF, 16'h0304, CW'(3), 1, 3};
`else
        vecs[3] = '{16'h0102, 16'hFFFF, 16'h0304, CW'(3), 1, 9};
`endif
        for (int i = 0; i < DEPTH; i++) tbl_m[i] = '0;

        arstn = 1'b0;
        repeat (3) tick();
        chk("rst_tvalid", m_axis.tvalid, 0);
        chk("rst_tdata", m_axis.tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        arstn = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) write_entry(i, 16'(i * 16'h0101));

        for (int v = 0; v < 4; v++) begin
            write_entry(0, vecs[v].e0);
            write_entry(1, vecs[v].e1);
            write_entry(2, vecs[v].e2);
            run_seq(vecs[v].cnt, vecs[v].mode, 1'b0, 1'b0, 16'h0000, vecs[v].exp_nb);
        end

        // Reset while beat 1 is pending, then rerun from entry 0.
        write_entry(0, 16'h1234);
        write_entry(1, 16'hABCD);
        ready_mode = 3;
        tready     = 1'b0;
        cmd_cnt    = CW'(2);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !m_axis.tvalid; i++) tick();
        chk("tvalid_rise", m_axis.tvalid, 1);
        tready = 1'b1;
        tick();
        tready = 1'b0;
        chk("beat1_pending_valid", m_axis.tvalid, 1);
        chk("beat1_pending_data", m_axis.tdata, 8'h12);
        tick();
        arstn = 1'b0;
        tick();
        chk("midrst_tvalid", m_axis.tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        arstn = 1'b1;
        tick();
        run_seq(CW'(2), 1, 1'b0, 1'b0, 16'h0000, 6);

        // Write while busy is dropped; rerun shows the original entry 0.
        run_seq(CW'(2), 1, 1'b1, 1'b0, 16'hDEAD, 6);
        run_seq(CW'(2), 1, 1'b0, 1'b0, 16'h0000, 6);

        // Write in the same cycle as start is seen by the fetch.
        run_seq(CW'(2), 1, 1'b0, 1'b1, 16'h5A5A, 6);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) write_entry(i, 16'($urandom));
            run_seq(CW'($urandom_range(0, 2 * DEPTH - 1)), int'($urandom_range(1, 2)),
                    1'b0, 1'b0, 16'h0000, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
